io_bank_ctrl: RTL
=================

IO_BANK_CTRL -- requirements
Module: io_bank_ctrl

Interface
REQ-001 SHALL have parameter NUM_HEX, default 8, number of 32-bit seven-segment display registers (legal 1..8).
REQ-002 SHALL have parameter SW_W, default 32, switch input width (legal 1..32).
REQ-003 SHALL have parameter DEB_CYC, default 16, debounce stability cycles (legal 2..65535).
REQ-004 SHALL have ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_ni  in  1  reset; synchronous, active-low.
- req_valid_i  in  1  bus request valid.
- req_ready_o  out  1  request accepted when valid and ready are both high.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  12  byte address; bits [1:0] ignored.
- req_wdata_i  in  32  write data.
- req_be_i  in  4  byte enables for writes.
- rsp_valid_o  out  1  read response valid.
- rsp_ready_i  in  1  read response accepted.
- rsp_rdata_o  out  32  read data.
- rsp_err_o  out  1  unmapped address flag, qualified by rsp_valid_o.
- io_sw_i  in  SW_W  raw asynchronous switches.
- io_ledr_o, io_ledg_o, io_lcd_o  out  32 each  register outputs.
- io_hex_o  out  NUM_HEX*32  display registers; slice k = HEX k.
- sw_irq_o  out  1  level copy of the sticky switch-change flag.

Function
REQ-005 SHALL use this address map: 0x000 LEDR RW; 0x010 LEDG RW; 0x020+4k HEX k RW for k<NUM_HEX; 0x040 LCD RW; 0x080 SW RO (debounced, zero-extended); 0x084 CHG (bit0 sticky flag, write 1 to clear). All other addresses are unmapped.
REQ-006 SHALL drive each output register directly from a flop, with no combinational path from the bus to any io_* output.
REQ-007 SHALL update a RW register on the clock edge of an accepted write, one byte lane per asserted req_be_i bit, and make the new value visible on io_* the following cycle.
REQ-008 SHALL ignore accepted writes to SW and to unmapped addresses, with no state change.
REQ-009 SHALL present read data on rsp_valid_o exactly one cycle after acceptance, with rsp_rdata_o and rsp_err_o held stable until rsp_ready_i is high.
REQ-010 SHALL return rdata = 0 and rsp_err_o = 1 for unmapped reads, including HEX k with k>=NUM_HEX.
REQ-011 SHALL drive req_ready_o = !rsp_valid_o || rsp_ready_i, allowing at most one outstanding read and back-to-back reads at full throughput when rsp_ready_i stays high.
REQ-012 SHALL accept writes under the same req_ready_o rule, and a write SHALL never produce a response.
REQ-013 SHALL pass io_sw_i through a two-flop synchroniser per bit into sync_sw.
REQ-014 SHALL debounce with one shared counter cnt:
- cnt is cleared when sync_sw == sw_stable, otherwise incremented.
- When cnt reaches DEB_CYC-1 with sync_sw != sw_stable: sw_stable <= sync_sw and cnt <= 0.
REQ-015 SHALL set the CHG flag in the same cycle sw_stable changes value.
REQ-016 SHALL give set priority over clear when a CHG set and a write-1 clear occur in the same cycle.
REQ-017 SHALL return the debounced value at the time of acceptance for a SW read; any sw_stable update in that cycle becomes visible on the next read.

Reset
REQ-018 SHALL, while rst_ni is low at a clock edge, clear all registers, LEDs, HEX, LCD, synchroniser flops, sw_stable, cnt, CHG, rsp_valid_o, rsp_rdata_o and rsp_err_o to 0.
REQ-019 SHALL drive req_ready_o = 1 during and after reset.
REQ-020 SHALL discard a read response pending when reset is asserted, with no response after reset.

Verification
REQ-021 Write 0xDEADBEEF to 0x000 with be=0xF, then 0x11223344 to 0x000 with be=0x3 -> io_ledr_o = 0xDEAD3344 one cycle after the second write.
REQ-022 Read 0x028 with NUM_HEX=8 after writing 0x7F -> rsp_valid_o one cycle later, rdata = 0x7F; with NUM_HEX=2 -> rdata = 0, rsp_err_o = 1.
REQ-023 Hold rsp_ready_i low for 3 cycles during a read -> rsp data stable, req_ready_o = 0 for 3 cycles, no second request accepted.
REQ-024 Toggle io_sw_i bit0 with a 5-cycle glitch, DEB_CYC=16 -> SW reads 0, CHG stays 0; hold 1 for >=18 cycles -> SW reads 0x1, CHG = 1, sw_irq_o = 1.
REQ-025 Write 0x1 to 0x084 in the same cycle a debounced change occurs -> CHG remains 1; a later clear with no change -> CHG = 0.
REQ-026 Assert rst_ni low for one edge with a response pending and LEDs set -> all outputs 0, rsp_valid_o = 0, req_ready_o = 1.

Source files
------------

// File: rtl/io_bank_ctrl.sv
// io_bank_ctrl: memory-mapped register bank for board I/O.
// Holds LED, seven-segment and LCD output registers, and a debounced switch
// input with a sticky change flag. Bus reads answer one cycle after acceptance.
module io_bank_ctrl #(
    parameter int unsigned NUM_HEX = 8,
    parameter int unsigned SW_W    = 32,
    parameter int unsigned DEB_CYC = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_we_i,
    input  logic [11:0]            req_addr_i,
    input  logic [31:0]            req_wdata_i,
    input  logic [3:0]             req_be_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    input  logic [SW_W-1:0]        io_sw_i,
    output logic [31:0]            io_ledr_o,
    output logic [31:0]            io_ledg_o,
    output logic [31:0]            io_lcd_o,
    output logic [NUM_HEX*32-1:0]  io_hex_o,
    output logic                   sw_irq_o
);

    // Word addresses (byte address >> 2)
    localparam logic [9:0]  W_LEDR   = 10'd0;
    localparam logic [9:0]  W_LEDG   = 10'd4;
    localparam logic [9:0]  W_HEX0   = 10'd8;
    localparam logic [9:0]  W_LCD    = 10'd16;
    localparam logic [9:0]  W_SW     = 10'd32;
    localparam logic [9:0]  W_CHG    = 10'd33;
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYC - 1);

    logic [9:0]      word;
    logic            accept;
    logic            wr;
    logic            rd;
    logic [31:0]     rd_data;
    logic            rd_err;
    logic [SW_W-1:0] sync1;
    logic [SW_W-1:0] sync_sw;
    logic [SW_W-1:0] sw_stable;
    logic [15:0]     cnt;
    logic            deb_done;
    logic            chg;
    logic            chg_set;
    logic            chg_clr;
    logic            unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] cur,
                                          input logic [31:0] wdata,
                                          input logic [3:0]  be);
        logic [31:0] res;
        res = cur;
        for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

    assign word        = req_addr_i[11:2];
    assign unused_addr = ^req_addr_i[1:0];

    // Ready is forced high in reset so the bus never stalls on a response
    // that the reset is about to discard.
    assign req_ready_o = !rst_ni || !rsp_valid_o || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;
    assign wr          = accept && req_we_i;
    assign rd          = accept && !req_we_i;

    assign deb_done = (cnt == DEB_LAST);
    assign chg_set  = (sync_sw != sw_stable) && deb_done;
    assign chg_clr  = wr && (word == W_CHG) && req_be_i[0] && req_wdata_i[0];
    assign sw_irq_o = chg;

    // Read data and unmapped-address decode for the current request
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (word)
            W_LEDR:  rd_data = io_ledr_o;
            W_LEDG:  rd_data = io_ledg_o;
            W_LCD:   rd_data = io_lcd_o;
            W_SW:    rd_data[SW_W-1:0] = sw_stable;
            W_CHG:   rd_data[0] = chg;
            default: begin
                rd_err = 1'b1;
                for (int unsigned k = 0; k < NUM_HEX; k++) begin
                    if (word == W_HEX0 + 10'(k)) begin
                        rd_data = io_hex_o[k*32 +: 32];
                        rd_err  = 1'b0;
                    end
                end
            end
        endcase
    end

    // Output registers, byte-lane writes on accepted requests
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            io_ledr_o <= '0;
            io_ledg_o <= '0;
            io_lcd_o  <= '0;
            io_hex_o  <= '0;
        end else if (wr) begin
            if (word == W_LEDR) io_ledr_o <= merge(io_ledr_o, req_wdata_i, req_be_i);
            if (word == W_LEDG) io_ledg_o <= merge(io_ledg_o, req_wdata_i, req_be_i);
            if (word == W_LCD)  io_lcd_o  <= merge(io_lcd_o,  req_wdata_i, req_be_i);
            for (int unsigned k = 0; k < NUM_HEX; k++) begin
                if (word == W_HEX0 + 10'(k))
                    io_hex_o[k*32 +: 32] <= merge(io_hex_o[k*32 +: 32], req_wdata_i, req_be_i);
            end
        end
    end

    // Read response register: loads on a read, held until the consumer takes it
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
        end else if (rd) begin
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= rd_data;
            rsp_err_o   <= rd_err;
        end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
        end
    end

    // Switch synchroniser, shared-counter debounce and sticky change flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync1     <= '0;
            sync_sw   <= '0;
            sw_stable <= '0;
            cnt       <= '0;
            chg       <= 1'b0;
        end else begin
            sync1   <= io_sw_i;
            sync_sw <= sync1;
            if (sync_sw == sw_stable) begin
                cnt <= '0;
            end else if (deb_done) begin
                sw_stable <= sync_sw;
                cnt       <= '0;
            end else begin
                cnt <= cnt + 16'd1;
            end
            if (chg_set)      chg <= 1'b1;
            else if (chg_clr) chg <= 1'b0;
        end
    end

endmodule
